mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single external memory bus between the fetch stage (instruction reads) and the mem_access stage (data loads/stores).
- Latches each granted request and sequences the bus handshake (req / active-low ready / busy).
- Returns read data and an active-low completion strobe to the winning requester.
- Exports grant flags so the stall/nop controller can hold the losing stage.
- Data accesses have priority; a starvation counter guarantees fetch progress; a timeout aborts hung transfers.

Parameters:
STARVE_LIMIT, 4, consecutive data grants allowed while if_req is pending before fetch is forced to win
TIMEOUT, 255, cycles in a bus state without bready_n=0 before abort (counter width 8)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
if_req  in  1  fetch request, held until if_ready_n pulse
if_addr  in  32  fetch address
if_ready_n  out  1  low for one cycle: if_rdata valid
if_rdata  out  32  fetched instruction
mem_req  in  1  data request, held until mem_ready_n pulse
mem_write  in  1  1=store, 0=load
mem_addr  in  32  data address
mem_size  in  2  00 byte, 01 half, 10 word
mem_wdata  in  32  store data
mem_ready_n  out  1  low for one cycle: transfer complete / mem_rdata valid
mem_rdata  out  32  load data
grant_if  out  1  fetch owns bus (BUS_IF or RESP_IF)
grant_mem  out  1  data owns bus (BUS_MEM or RESP_MEM)
bus_err  out  1  one-cycle pulse with ready strobe on timeout abort
baddr  out  32  bus address
bsize  out  2  bus size (fetch always 10)
breq  out  1  bus request
bwrite  out  1  bus write enable
bwdata  out  32  bus write data
brdata  in  32  bus read data
bready_n  in  1  bus completion, active-low
bbusy  in  1  bus cannot accept a new request

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; starve_cnt=0; tmo_cnt=0.
  - Output values during reset: breq=0, bwrite=0, baddr=0, bsize=0, bwdata=0.
  - if_ready_n=1, mem_ready_n=1, if_rdata=0, mem_rdata=0, grant_if=0, grant_mem=0, bus_err=0.
- Reset mid-transfer: the transaction is abandoned and no ready strobe is issued.
- All outputs are registered.
- FSM states: IDLE, BUS_IF, BUS_MEM, RESP_IF, RESP_MEM.
- IDLE:
  - bbusy=1: stay.
  - Else, if mem_req=1 and not (if_req=1 and starve_cnt==STARVE_LIMIT): go to BUS_MEM.
  - Else if if_req=1: go to BUS_IF.
  - Else: stay.
  - On the transition edge, latch the winner's addr/size/write/wdata onto baddr/bsize/bwrite/bwdata and set breq=1.
- Starvation counter:
  - starve_cnt increments (saturating at STARVE_LIMIT) on each data grant made while if_req=1.
  - It clears on every fetch grant, and on a data grant made while if_req=0.
- BUS_x:
  - breq held at 1; latched bus signals held constant.
  - tmo_cnt increments each cycle.
  - bready_n=0 sampled: capture brdata into if_rdata or mem_rdata (mem_rdata updates on loads only). Go to RESP_x; breq=0, bwrite=0, bwdata=0; tmo_cnt=0.
  - tmo_cnt==TIMEOUT without ready: go to RESP_x with bus_err=1 for the RESP cycle; rdata is not updated; breq dropped.
- RESP_x: the matching ready_n=0 for exactly one cycle, then IDLE. Next arbitration happens in IDLE.
  - Minimum latency: request seen in cycle 0 → breq in cycle 1 → bready_n=0 in cycle 1 → ready_n=0 in cycle 2.
  - At most one transfer per 3 cycles.
- bbusy is ignored once in a BUS state.
- Requester deasserting req mid-transfer: the transfer still completes and ready still pulses. The requester must ignore the pulse.
- grant_if/grant_mem are mutually exclusive and never both 1. They are 0 in IDLE.
- Simultaneous if_req and mem_req with starve_cnt<STARVE_LIMIT: data wins.
- Simultaneous if_req and mem_req with starve_cnt==STARVE_LIMIT: fetch wins.

Test Plan:
- Single fetch: if_req=1, if_addr=0x100, bready_n low in the first BUS cycle with brdata=0x00500093 → breq=1 and baddr=0x100, bsize=10 in cycle 1; if_ready_n=0 and if_rdata=0x00500093 in cycle 2; grant_if=1 in cycles 1–2.
- Store: mem_req=1, mem_write=1, addr=0x2000, size=01, wdata=0xBEEF, bready_n delayed 3 cycles → bwrite=1, bwdata=0xBEEF held 4 cycles; one mem_ready_n pulse; mem_rdata unchanged.
- Contention with STARVE_LIMIT=4: if_req and mem_req both held high → grant order is 4 data grants, 1 fetch grant, repeating.
- Busy: bbusy=1 for 5 cycles with mem_req=1 → breq stays 0 for those cycles; breq=1 on the cycle after bbusy falls.
- Timeout with TIMEOUT=255: if_req=1, bready_n stuck at 1 → breq drops after 255 BUS cycles; if_ready_n=0 and bus_err=1 together for one cycle; FSM returns to IDLE.
- Async reset during BUS_MEM: rst=0 between clock edges → breq=0, grants=0, state=IDLE immediately; no mem_ready_n pulse after reset is released.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Shares one external memory bus between instruction fetch and
//               data access, with data priority, starvation guard and timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready_n,
    output logic [31:0] if_rdata,
    input  logic        mem_req,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_wdata,
    output logic        mem_ready_n,
    output logic [31:0] mem_rdata,
    output logic        grant_if,
    output logic        grant_mem,
    output logic        bus_err,
    output logic [31:0] baddr,
    output logic [1:0]  bsize,
    output logic        breq,
    output logic        bwrite,
    output logic [31:0] bwdata,
    input  logic [31:0] brdata,
    input  logic        bready_n,
    input  logic        bbusy
);

    localparam int            SW           = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] C_STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [7:0]    C_TMO_MAX    = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_BUS_IF   = 3'd1,
        ST_BUS_MEM  = 3'd2,
        ST_RESP_IF  = 3'd3,
        ST_RESP_MEM = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;
    logic [7:0]  tmo_inc;
    logic        starve_full;

    logic        breq_q, breq_d;
    logic        bwrite_q, bwrite_d;
    logic [31:0] baddr_q, baddr_d;
    logic [1:0]  bsize_q, bsize_d;
    logic [31:0] bwdata_q, bwdata_d;
    logic        if_ready_n_q, if_ready_n_d;
    logic        mem_ready_n_q, mem_ready_n_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        grant_if_q, grant_if_d;
    logic        grant_mem_q, grant_mem_d;
    logic        bus_err_q, bus_err_d;

    assign starve_full = (starve_cnt_q == C_STARVE_MAX);

    always_comb begin
        state_d       = state_q;
        starve_cnt_d  = starve_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        tmo_inc       = tmo_cnt_q + 8'd1;
        breq_d        = breq_q;
        bwrite_d      = bwrite_q;
        baddr_d       = baddr_q;
        bsize_d       = bsize_q;
        bwdata_d      = bwdata_q;
        if_rdata_d    = if_rdata_q;
        mem_rdata_d   = mem_rdata_q;
        grant_if_d    = grant_if_q;
        grant_mem_d   = grant_mem_q;
        if_ready_n_d  = 1'b1;
        mem_ready_n_d = 1'b1;
        bus_err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tmo_cnt_d = '0;
                if (!bbusy) begin
                    if (mem_req && !(if_req && starve_full)) begin
                        state_d     = ST_BUS_MEM;
                        breq_d      = 1'b1;
                        baddr_d     = mem_addr;
                        bsize_d     = mem_size;
                        bwrite_d    = mem_write;
                        bwdata_d    = mem_wdata;
                        grant_mem_d = 1'b1;
                        // Only grants that actually bypass a waiting fetch count toward starvation
                        if (!if_req) begin
                            starve_cnt_d = '0;
                        end else if (!starve_full) begin
                            starve_cnt_d = starve_cnt_q + 1'b1;
                        end
                    end else if (if_req) begin
                        state_d      = ST_BUS_IF;
                        breq_d       = 1'b1;
                        baddr_d      = if_addr;
                        bsize_d      = 2'b10;
                        bwrite_d     = 1'b0;
                        bwdata_d     = '0;
                        grant_if_d   = 1'b1;
                        starve_cnt_d = '0;
                    end
                end
            end

            ST_BUS_IF, ST_BUS_MEM: begin
                if (!bready_n || (tmo_inc == C_TMO_MAX)) begin
                    state_d   = (state_q == ST_BUS_MEM) ? ST_RESP_MEM : ST_RESP_IF;
                    breq_d    = 1'b0;
                    bwrite_d  = 1'b0;
                    bwdata_d  = '0;
                    tmo_cnt_d = '0;
                    if (state_q == ST_BUS_MEM) begin
                        mem_ready_n_d = 1'b0;
                    end else begin
                        if_ready_n_d = 1'b0;
                    end
                    // A real completion wins over a coincident timeout
                    if (!bready_n) begin
                        if (state_q == ST_BUS_IF) begin
                            if_rdata_d = brdata;
                        end else if (!bwrite_q) begin
                            mem_rdata_d = brdata;
                        end
                    end else begin
                        bus_err_d = 1'b1;
                    end
                end else begin
                    tmo_cnt_d = tmo_inc;
                end
            end

            ST_RESP_IF, ST_RESP_MEM: begin
                state_d     = ST_IDLE;
                grant_if_d  = 1'b0;
                grant_mem_d = 1'b0;
            end

            default: begin
                state_d     = ST_IDLE;
                breq_d      = 1'b0;
                grant_if_d  = 1'b0;
                grant_mem_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            starve_cnt_q  <= '0;
            tmo_cnt_q     <= '0;
            breq_q        <= 1'b0;
            bwrite_q      <= 1'b0;
            baddr_q       <= '0;
            bsize_q       <= '0;
            bwdata_q      <= '0;
            if_ready_n_q  <= 1'b1;
            mem_ready_n_q <= 1'b1;
            if_rdata_q    <= '0;
            mem_rdata_q   <= '0;
            grant_if_q    <= 1'b0;
            grant_mem_q   <= 1'b0;
            bus_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            starve_cnt_q  <= starve_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            breq_q        <= breq_d;
            bwrite_q      <= bwrite_d;
            baddr_q       <= baddr_d;
            bsize_q       <= bsize_d;
            bwdata_q      <= bwdata_d;
            if_ready_n_q  <= if_ready_n_d;
            mem_ready_n_q <= mem_ready_n_d;
            if_rdata_q    <= if_rdata_d;
            mem_rdata_q   <= mem_rdata_d;
            grant_if_q    <= grant_if_d;
            grant_mem_q   <= grant_mem_d;
            bus_err_q     <= bus_err_d;
        end
    end

    assign breq        = breq_q;
    assign bwrite      = bwrite_q;
    assign baddr       = baddr_q;
    assign bsize       = bsize_q;
    assign bwdata      = bwdata_q;
    assign if_ready_n  = if_ready_n_q;
    assign mem_ready_n = mem_ready_n_q;
    assign if_rdata    = if_rdata_q;
    assign mem_rdata   = mem_rdata_q;
    assign grant_if    = grant_if_q;
    assign grant_mem   = grant_mem_q;
    assign bus_err     = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Directed scenarios plus randomized traffic against a
//               transaction-level model of the memory bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req, mem_req, mem_write, bready_n, bbusy;
    logic [31:0] if_addr, mem_addr, mem_wdata, brdata;
    logic [1:0]  mem_size;
    logic        if_ready_n, mem_ready_n, grant_if, grant_mem, bus_err, breq, bwrite;
    logic [31:0] if_rdata, mem_rdata, baddr, bwdata;
    logic [1:0]  bsize;

    int checks   = 0;
    int failures = 0;

    mem_bus_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready_n(if_ready_n), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_size(mem_size),
        .mem_wdata(mem_wdata), .mem_ready_n(mem_ready_n), .mem_rdata(mem_rdata),
        .grant_if(grant_if), .grant_mem(grant_mem), .bus_err(bus_err),
        .baddr(baddr), .bsize(bsize), .breq(breq), .bwrite(bwrite), .bwdata(bwdata),
        .brdata(brdata), .bready_n(bready_n), .bbusy(bbusy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 0; if_addr = 0; mem_req = 0; mem_write = 0; mem_addr = 0;
        mem_size = 0; mem_wdata = 0; bready_n = 1; brdata = 0; bbusy = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        #2;
        rst = 0;
        #1;
        checks++;
        if ({breq, bwrite, grant_if, grant_mem, bus_err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=00000", {breq, bwrite, grant_if, grant_mem, bus_err});
        end
        checks++;
        if ({baddr, bsize, bwdata, if_rdata, mem_rdata} !== 130'd0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", {baddr, bsize, bwdata, if_rdata, mem_rdata});
        end
        checks++;
        if ({if_ready_n, mem_ready_n} !== 2'b11) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=11", {if_ready_n, mem_ready_n});
        end
        @(posedge clk);
        #1;
        rst = 1;
    endtask

    task automatic test_single_fetch();
        if_req = 1; if_addr = 32'h100; bready_n = 0; brdata = 32'h00500093;
        tick();
        checks++;
        if ({breq, grant_if, grant_mem, if_ready_n} !== 4'b1101 || baddr !== 32'h100 || bsize !== 2'b10) begin
            failures++;
            $display("FAIL fetch_c1 got=breq%b gif%b gmem%b rdy%b addr%h size%b exp=breq1 gif1 gmem0 rdy1 addr100 size10",
                     breq, grant_if, grant_mem, if_ready_n, baddr, bsize);
        end
        tick();
        checks++;
        if (if_ready_n !== 1'b0 || if_rdata !== 32'h00500093 || grant_if !== 1'b1 || breq !== 1'b0) begin
            failures++;
            $display("FAIL fetch_c2 got=rdy%b data%h gif%b breq%b exp=rdy0 data00500093 gif1 breq0",
                     if_ready_n, if_rdata, grant_if, breq);
        end
        if_req = 0; bready_n = 1;
        tick();
        checks++;
        if (if_ready_n !== 1'b1 || grant_if !== 1'b0) begin
            failures++;
            $display("FAIL fetch_c3 got=rdy%b gif%b exp=rdy1 gif0", if_ready_n, grant_if);
        end
    endtask

    task automatic test_store();
        int pulses = 0;
        mem_req = 1; mem_write = 1; mem_addr = 32'h2000; mem_size = 2'b01;
        mem_wdata = 32'hBEEF; bready_n = 1; brdata = 32'hDEADDEAD;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (breq !== 1'b1 || bwrite !== 1'b1 || bwdata !== 32'hBEEF || baddr !== 32'h2000 ||
                bsize !== 2'b01 || grant_mem !== 1'b1 || mem_ready_n !== 1'b1) begin
                failures++;
                $display("FAIL store_hold%0d got=breq%b wr%b wd%h a%h s%b g%b r%b exp=breq1 wr1 wdbeef a2000 s01 g1 r1",
                         i, breq, bwrite, bwdata, baddr, bsize, grant_mem, mem_ready_n);
            end
            if (i == 4) bready_n = 0;
        end
        tick();
        checks++;
        if (mem_ready_n !== 1'b0 || mem_rdata !== 32'h0 || bwrite !== 1'b0 || breq !== 1'b0) begin
            failures++;
            $display("FAIL store_done got=rdy%b rdata%h wr%b breq%b exp=rdy0 rdata0 wr0 breq0",
                     mem_ready_n, mem_rdata, bwrite, breq);
        end
        mem_req = 0; bready_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (mem_ready_n === 1'b0) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL store_extra_pulse got=%0d exp=0", pulses);
        end
    endtask

    task automatic test_busy();
        int early = 0;
        mem_req = 1; mem_write = 0; mem_addr = 32'h3000; mem_size = 2'b10; bbusy = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (breq !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            failures++;
            $display("FAIL busy_hold got=%0d breq cycles exp=0", early);
        end
        bbusy = 0;
        tick();
        checks++;
        if (breq !== 1'b1 || grant_mem !== 1'b1) begin
            failures++;
            $display("FAIL busy_release got=breq%b g%b exp=breq1 g1", breq, grant_mem);
        end
        bbusy = 1; bready_n = 0; brdata = 32'h12345678;
        tick();
        checks++;
        if (mem_ready_n !== 1'b0 || mem_rdata !== 32'h12345678) begin
            failures++;
            $display("FAIL busy_load got=rdy%b data%h exp=rdy0 data12345678", mem_ready_n, mem_rdata);
        end
        mem_req = 0; bready_n = 1; bbusy = 0;
        tick();
    endtask

    task automatic test_timeout();
        int cnt = 0;
        if_req = 1; if_addr = 32'h400; bready_n = 1; brdata = 32'hFFFF0000;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (breq === 1'b1) cnt++;
            else if (cnt > 0) break;
        end
        checks++;
        if (cnt != 255) begin
            failures++;
            $display("FAIL timeout_len got=%0d exp=255", cnt);
        end
        checks++;
        if (if_ready_n !== 1'b0 || bus_err !== 1'b1 || if_rdata !== 32'h00500093 || grant_if !== 1'b1) begin
            failures++;
            $display("FAIL timeout_resp got=rdy%b err%b data%h g%b exp=rdy0 err1 data00500093 g1",
                     if_ready_n, bus_err, if_rdata, grant_if);
        end
        if_req = 0;
        tick();
        checks++;
        if (if_ready_n !== 1'b1 || bus_err !== 1'b0 || grant_if !== 1'b0) begin
            failures++;
            $display("FAIL timeout_idle got=rdy%b err%b g%b exp=rdy1 err0 g0", if_ready_n, bus_err, grant_if);
        end
    endtask

    task automatic test_async_reset();
        int pulses = 0;
        int grants = 0;
        mem_req = 1; mem_write = 0; mem_addr = 32'h5000; mem_size = 2'b10; bready_n = 1;
        tick();
        tick();
        checks++;
        if (grant_mem !== 1'b1 || breq !== 1'b1) begin
            failures++;
            $display("FAIL arst_pre got=g%b breq%b exp=g1 breq1", grant_mem, breq);
        end
        @(negedge clk);
        rst = 0;
        #1;
        checks++;
        if ({breq, grant_if, grant_mem, mem_ready_n} !== 4'b0001) begin
            failures++;
            $display("FAIL arst_now got=%b exp=0001", {breq, grant_if, grant_mem, mem_ready_n});
        end
        mem_req = 0; bready_n = 0;
        @(posedge clk);
        #3;
        rst = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (mem_ready_n === 1'b0) pulses++;
            if (grant_mem === 1'b1 || breq === 1'b1) grants++;
        end
        checks++;
        if (pulses != 0 || grants != 0) begin
            failures++;
            $display("FAIL arst_after got=pulses%0d busy%0d exp=0 0", pulses, grants);
        end
        bready_n = 1;
    endtask

    task automatic test_contention();
        logic   prev_any = 1'b0;
        logic   order[$];
        do_reset();
        if_req = 1; if_addr = 32'h600; mem_req = 1; mem_write = 0; mem_addr = 32'h700;
        mem_size = 2'b10; bready_n = 0; brdata = 32'hA5A5A5A5;
        for (int i = 0; i < 40; i++) begin
            tick();
            if ((grant_if === 1'b1 || grant_mem === 1'b1) && !prev_any) order.push_back(grant_mem);
            prev_any = grant_if | grant_mem;
        end
        idle_inputs();
        tick();
        tick();
        checks++;
        if (order.size() < 10) begin
            failures++;
            $display("FAIL contention_count got=%0d exp>=10", order.size());
        end else begin
            for (int k = 0; k < 10; k++) begin
                checks++;
                if (order[k] !== ((k % 5) != 4)) begin
                    failures++;
                    $display("FAIL contention_grant%0d got=data%b exp=data%b", k, order[k], (k % 5) != 4);
                end
            end
        end
    endtask

    task automatic test_random();
        int          arb_edge = 1;
        int          g = 0, d = 0, starve = 0;
        bit          active = 0, owner_mem = 0, pulse, in_bus;
        logic [31:0] t_addr = 0, t_wdata = 0, t_rdata = 0, exp_if = 0, exp_mem = 0;
        logic [1:0]  t_size = 0;
        logic        t_write = 0;
        do_reset();
        for (int e = 1; e <= 600; e++) begin
            tick();
            // arbitration sees the inputs held across this edge
            if (e == arb_edge) begin
                if (!bbusy && (if_req || mem_req)) begin
                    owner_mem = mem_req && !(if_req && starve == 4);
                    if (owner_mem) starve = if_req ? ((starve < 4) ? starve + 1 : 4) : 0;
                    else starve = 0;
                    if (owner_mem) begin
                        t_addr = mem_addr; t_size = mem_size; t_write = mem_write; t_wdata = mem_wdata;
                    end else begin
                        t_addr = if_addr; t_size = 2'b10; t_write = 0; t_wdata = 0;
                    end
                    g = e; d = $urandom_range(0, 3); t_rdata = $urandom;
                    active = 1; arb_edge = e + d + 3;
                end else begin
                    arb_edge = e + 1;
                end
            end
            pulse  = active && (e == g + d + 1);
            in_bus = active && (e <= g + d);
            if (pulse) begin
                if (!owner_mem) exp_if = t_rdata;
                else if (!t_write) exp_mem = t_rdata;
            end
            checks++;
            if (breq !== in_bus || grant_mem !== (active && owner_mem) || grant_if !== (active && !owner_mem) ||
                bus_err !== 1'b0) begin
                failures++;
                $display("FAIL rnd_ctrl e=%0d got=breq%b gm%b gi%b err%b exp=breq%b gm%b gi%b err0",
                         e, breq, grant_mem, grant_if, bus_err, in_bus, active && owner_mem, active && !owner_mem);
            end
            checks++;
            if (if_ready_n !== !(pulse && !owner_mem) || mem_ready_n !== !(pulse && owner_mem)) begin
                failures++;
                $display("FAIL rnd_ready e=%0d got=if%b mem%b exp=if%b mem%b",
                         e, if_ready_n, mem_ready_n, !(pulse && !owner_mem), !(pulse && owner_mem));
            end
            checks++;
            if (if_rdata !== exp_if || mem_rdata !== exp_mem) begin
                failures++;
                $display("FAIL rnd_rdata e=%0d got=if%h mem%h exp=if%h mem%h", e, if_rdata, mem_rdata, exp_if, exp_mem);
            end
            if (in_bus) begin
                checks++;
                if (baddr !== t_addr || bsize !== t_size || bwrite !== t_write || (owner_mem && bwdata !== t_wdata)) begin
                    failures++;
                    $display("FAIL rnd_bus e=%0d got=a%h s%b w%b d%h exp=a%h s%b w%b d%h",
                             e, baddr, bsize, bwrite, bwdata, t_addr, t_size, t_write, t_wdata);
                end
            end
            if (pulse) begin
                if (owner_mem) mem_req = 0;
                else if_req = 0;
                active = 0;
            end
            bready_n = !(in_bus && e == g + d);
            brdata   = (in_bus && e == g + d) ? t_rdata : $urandom;
            bbusy    = ($urandom_range(0, 3) == 0);
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1; if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!mem_req && $urandom_range(0, 2) == 0) begin
                mem_req = 1; mem_addr = $urandom; mem_wdata = $urandom;
                mem_write = 1'($urandom_range(0, 1)); mem_size = 2'($urandom_range(0, 2));
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_fetch();
        test_store();
        test_busy();
        test_timeout();
        test_async_reset();
        test_contention();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
